// File: rtl/tcdm_arb_pkg.sv
// rtl/tcdm_arb_pkg.sv - shared types and constants for the TCDM bank arbiter
// Purpose: policy enum, request payload struct, index-width helper.
// Ports: none (package).
package tcdm_arb_pkg;

    localparam int TCDM_AW = 13;
    localparam int TCDM_DW = 32;
    localparam int TCDM_BW = TCDM_DW / 8;
    localparam int TCDM_IW = 8;

    typedef enum logic [1:0] {
        POL_RR        = 2'd0,
        POL_FIXED     = 2'd1,
        POL_WEIGHTED  = 2'd2,
        POL_HWPE_PRIO = 2'd3
    } tcdm_arb_policy_e;

    typedef struct packed {
        logic [TCDM_AW-1:0] add;
        logic               wen;
        logic [TCDM_DW-1:0] data;
        logic [TCDM_BW-1:0] be;
        logic [TCDM_IW-1:0] id;
    } tcdm_arb_req_t;

    // Width of a channel index; never zero so a single channel still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcdm_bank_arbiter_if.sv
// rtl/tcdm_bank_arbiter_if.sv - channel-side and bank-side bus of the TCDM bank arbiter
// Purpose: bundles per-channel request/grant/response and the SRAM bank port.
// Ports: slave = arbiter view (channel requests and bank response in, grants,
//        responses and bank request out); master = initiator/bank model view.
interface tcdm_bank_arbiter_if #(
    parameter int N_CH = 4,
    parameter int DW   = 32,
    parameter int AW   = 13,
    parameter int BW   = DW / 8,
    parameter int IW   = 8
);
    logic [N_CH-1:0]          ch_req_i;
    logic [N_CH-1:0]          ch_gnt_o;
    logic [N_CH-1:0][AW-1:0]  ch_add_i;
    logic [N_CH-1:0]          ch_wen_i;
    logic [N_CH-1:0][DW-1:0]  ch_data_i;
    logic [N_CH-1:0][BW-1:0]  ch_be_i;
    logic [N_CH-1:0][IW-1:0]  ch_id_i;
    logic [N_CH-1:0]          ch_r_valid_o;
    logic [DW-1:0]            ch_r_data_o;
    logic [IW-1:0]            ch_r_id_o;
    logic                     mem_req_o;
    logic [AW-1:0]            mem_add_o;
    logic                     mem_wen_o;
    logic [DW-1:0]            mem_data_o;
    logic [BW-1:0]            mem_be_o;
    logic                     mem_gnt_i;
    logic [DW-1:0]            mem_r_data_i;

    modport slave (
        input  ch_req_i, ch_add_i, ch_wen_i, ch_data_i, ch_be_i, ch_id_i,
        input  mem_gnt_i, mem_r_data_i,
        output ch_gnt_o, ch_r_valid_o, ch_r_data_o, ch_r_id_o,
        output mem_req_o, mem_add_o, mem_wen_o, mem_data_o, mem_be_o
    );

    modport master (
        output ch_req_i, ch_add_i, ch_wen_i, ch_data_i, ch_be_i, ch_id_i,
        output mem_gnt_i, mem_r_data_i,
        input  ch_gnt_o, ch_r_valid_o, ch_r_data_o, ch_r_id_o,
        input  mem_req_o, mem_add_o, mem_wen_o, mem_data_o, mem_be_o
    );
endinterface

// File: rtl/tcdm_arb_pick.sv
// rtl/tcdm_arb_pick.sv - combinational rotate-priority picker
// Purpose: first set bit of req_i found walking from start_i, upward (dir_i=0)
//          or downward (dir_i=1), wrapping at N.
// Ports: req_i request vector, start_i first index examined, dir_i direction,
//        idx_o winner index, valid_o any request present.
module tcdm_arb_pick
    import tcdm_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int XW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [XW-1:0] start_i,
    input  logic          dir_i,
    output logic [XW-1:0] idx_o,
    output logic          valid_o
);

    logic [XW-1:0] cand;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            if (dir_i) cand = XW'((int'(start_i) + N - i) % N);
            else       cand = XW'((int'(start_i) + i) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// rtl/tcdm_bank_arbiter.sv - per-bank N-channel TCDM arbiter with selectable policy
// Purpose: grants one channel per cycle to the SRAM bank (combinational grant),
//          returns the response one cycle later to the granted channel.
// Ports: clk_i, rst_i (async, active-high), clear_i (sync clear), policy_i,
//        weight_i (per-channel budgets), bus (channel + bank signals, slave
//        modport), starve_o (current grant is a starvation override).
// Option: TCDM_ARB_STARVATION_EN builds stall counters, override and starve_o.
module tcdm_bank_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DW        = TCDM_DW,
    parameter int AW        = TCDM_AW,
    parameter int BW        = DW / 8,
    parameter int IW        = TCDM_IW,
    parameter int WEIGHT_W  = 4,
    parameter int MAX_STALL = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic [1:0]               policy_i,
    input  logic [N_CH*WEIGHT_W-1:0] weight_i,
    tcdm_bank_arbiter_if.slave       bus,
    output logic                     starve_o
);

    localparam int XW = idx_width(N_CH);
    localparam int SW = idx_width(MAX_STALL + 1);

    function automatic logic [XW-1:0] wrap_inc(input logic [XW-1:0] x);
        return (int'(x) == N_CH - 1) ? '0 : x + 1'b1;
    endfunction

    tcdm_arb_policy_e policy;
    assign policy = tcdm_arb_policy_e'(policy_i);

    logic [XW-1:0]       ptr_q, ptr_d, owner_q, owner_d;
    logic [WEIGHT_W-1:0] budget_q, budget_d;
    logic [N_CH-1:0]     resp_ch_q, resp_ch_d;
    logic [IW-1:0]       resp_id_q, resp_id_d;

    logic [N_CH-1:0][WEIGHT_W-1:0] wt;
    logic [WEIGHT_W-1:0] owner_wt;
    logic                owner_keep;

    always_comb begin
        for (int i = 0; i < N_CH; i++) wt[i] = weight_i[i*WEIGHT_W +: WEIGHT_W];
        owner_wt = (wt[owner_q] == '0) ? WEIGHT_W'(1) : wt[owner_q];
    end

    // The weighted owner holds the bank while it asks and has budget left.
    assign owner_keep = bus.ch_req_i[owner_q] && (budget_q < owner_wt);

    // Round-robin search: from the pointer, or from owner+1 when weighted.
    logic [XW-1:0] rr_start, rr_idx, lo_idx, hi_idx;
    logic          rr_vld, lo_vld, hi_vld;
    assign rr_start = (policy == POL_WEIGHTED) ? wrap_inc(owner_q) : ptr_q;

    tcdm_arb_pick #(.N(N_CH), .XW(XW)) u_pick_rr (
        .req_i(bus.ch_req_i), .start_i(rr_start), .dir_i(1'b0),
        .idx_o(rr_idx), .valid_o(rr_vld));
    tcdm_arb_pick #(.N(N_CH), .XW(XW)) u_pick_lo (
        .req_i(bus.ch_req_i), .start_i('0), .dir_i(1'b0),
        .idx_o(lo_idx), .valid_o(lo_vld));
    tcdm_arb_pick #(.N(N_CH), .XW(XW)) u_pick_hi (
        .req_i(bus.ch_req_i), .start_i(XW'(N_CH - 1)), .dir_i(1'b1),
        .idx_o(hi_idx), .valid_o(hi_vld));

    logic [XW-1:0] ovr_idx;
    logic          ovr_vld;

`ifdef TCDM_ARB_STARVATION_EN
    logic [N_CH-1:0][SW-1:0] stall_q, stall_d;
    logic [N_CH-1:0]         stalled;

    always_comb begin
        for (int i = 0; i < N_CH; i++)
            stalled[i] = bus.ch_req_i[i] && (stall_q[i] == SW'(MAX_STALL));
    end

    tcdm_arb_pick #(.N(N_CH), .XW(XW)) u_pick_starve (
        .req_i(stalled), .start_i('0), .dir_i(1'b0),
        .idx_o(ovr_idx), .valid_o(ovr_vld));

    always_comb begin
        stall_d = stall_q;
        for (int i = 0; i < N_CH; i++) begin
            if (!bus.ch_req_i[i] || bus.ch_gnt_o[i]) stall_d[i] = '0;
            else if (stall_q[i] != SW'(MAX_STALL))   stall_d[i] = stall_q[i] + 1'b1;
        end
        if (clear_i) stall_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_q <= '0;
        else       stall_q <= stall_d;
    end
`else
    assign ovr_idx = '0;
    assign ovr_vld = 1'b0;
`endif

    logic [XW-1:0] pol_idx, win_idx;
    logic          pol_vld, grant;

    always_comb begin
        pol_idx = rr_idx;
        pol_vld = rr_vld;
        case (policy)
            POL_FIXED:     begin pol_idx = lo_idx; pol_vld = lo_vld; end
            POL_HWPE_PRIO: begin pol_idx = hi_idx; pol_vld = hi_vld; end
            POL_WEIGHTED:  if (owner_keep) begin pol_idx = owner_q; pol_vld = 1'b1; end
            default:       ;
        endcase
        win_idx = ovr_vld ? ovr_idx : pol_idx;
    end

    assign grant        = (pol_vld | ovr_vld) & bus.mem_gnt_i;
    assign bus.ch_gnt_o = grant ? (N_CH'(1) << win_idx) : '0;
    assign starve_o     = ovr_vld & bus.mem_gnt_i;

    assign bus.mem_req_o  = |bus.ch_req_i;
    assign bus.mem_add_o  = bus.ch_add_i[win_idx];
    assign bus.mem_wen_o  = bus.ch_wen_i[win_idx];
    assign bus.mem_data_o = bus.ch_data_i[win_idx];
    assign bus.mem_be_o   = bus.ch_be_i[win_idx];

    assign bus.ch_r_valid_o = resp_ch_q;
    assign bus.ch_r_id_o    = resp_id_q;
    assign bus.ch_r_data_o  = bus.mem_r_data_i;

    // Every grant moves the pointer and opens a new tenure, except a weighted
    // owner continuing on its own budget.
    always_comb begin
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        budget_d  = budget_q;
        resp_ch_d = '0;
        resp_id_d = resp_id_q;
        if (grant) begin
            ptr_d = wrap_inc(win_idx);
            if (policy == POL_WEIGHTED && owner_keep && !ovr_vld) begin
                budget_d = budget_q + 1'b1;
            end else begin
                owner_d  = win_idx;
                budget_d = WEIGHT_W'(1);
            end
            resp_ch_d = bus.ch_gnt_o;
            resp_id_d = bus.ch_id_i[win_idx];
        end
        if (clear_i) begin
            ptr_d     = '0;
            owner_d   = '0;
            budget_d  = '0;
            resp_ch_d = '0;
            resp_id_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            budget_q  <= '0;
            resp_ch_q <= '0;
            resp_id_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            budget_q  <= budget_d;
            resp_ch_q <= resp_ch_d;
            resp_id_q <= resp_id_d;
        end
    end

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// tb/tb_tcdm_bank_arbiter.sv - self-checking bench for tcdm_bank_arbiter
module tb_tcdm_bank_arbiter;
    import tcdm_arb_pkg::*;

    localparam int N_CH      = 4;
    localparam int MAX_STALL = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [1:0]  policy;
    logic [15:0] weight;
    logic        starve;
    logic [3:0]  req;
    logic        mem_gnt;
    logic [31:0] rdata;
    tcdm_arb_req_t pl [N_CH];

    int n_checks = 0;
    int n_fail   = 0;

    int m_ptr, m_owner, m_budget, m_resp_ch, m_resp_id;
    int m_stall [N_CH];
    logic [3:0] obs_gnt, obs_rv;
    logic [7:0] obs_rid;
    logic       obs_starve;

    tcdm_bank_arbiter_if bus ();

    tcdm_bank_arbiter dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .policy_i(policy),
        .weight_i(weight),
        .bus     (bus),
        .starve_o(starve)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_ptr = 0; m_owner = 0; m_budget = 0; m_resp_ch = -1; m_resp_id = 0;
        for (int i = 0; i < N_CH; i++) m_stall[i] = 0;
    endfunction

    function automatic int rr_from(input int s);
        for (int k = 0; k < N_CH; k++)
            if (req[(s + k) % N_CH]) return (s + k) % N_CH;
        return -1;
    endfunction

    function automatic int eff_weight(input int ch);
        int w = int'(weight[ch*4 +: 4]);
        return (w == 0) ? 1 : w;
    endfunction

    // Winner by the written policy rules; keep = weighted owner continues.
    function automatic void model_pick(output int w, output bit ovr, output bit keep);
        w = -1; ovr = 1'b0; keep = 1'b0;
`ifdef TCDM_ARB_STARVATION_EN
        for (int i = 0; i < N_CH; i++)
            if (!ovr && req[i] && m_stall[i] >= MAX_STALL) begin w = i; ovr = 1'b1; end
        if (ovr) return;
`endif
        case (policy)
            2'd0: w = rr_from(m_ptr);
            2'd1: for (int i = N_CH - 1; i >= 0; i--) if (req[i]) w = i;
            2'd2: begin
                keep = req[m_owner] && (m_budget < eff_weight(m_owner));
                w = keep ? m_owner : rr_from((m_owner + 1) % N_CH);
            end
            default: for (int i = 0; i < N_CH; i++) if (req[i]) w = i;
        endcase
    endfunction

    task automatic drive();
        for (int i = 0; i < N_CH; i++) begin
            bus.ch_add_i[i]  = pl[i].add;
            bus.ch_wen_i[i]  = pl[i].wen;
            bus.ch_data_i[i] = pl[i].data;
            bus.ch_be_i[i]   = pl[i].be;
            bus.ch_id_i[i]   = pl[i].id;
        end
        bus.ch_req_i     = req;
        bus.mem_gnt_i    = mem_gnt;
        bus.mem_r_data_i = rdata;
    endtask

    // Entered just after a rising edge: drive, check at the falling edge,
    // advance the model, return just after the next rising edge.
    task automatic step();
        int w;
        bit ovr, keep, g;
        drive();
        #4;
        model_pick(w, ovr, keep);
        g = (req != 4'b0) && mem_gnt;
        obs_gnt = bus.ch_gnt_o; obs_rv = bus.ch_r_valid_o;
        obs_rid = bus.ch_r_id_o; obs_starve = starve;
        check_val("gnt", obs_gnt, g ? (64'd1 << w) : 64'd0);
        check_val("starve", obs_starve, ovr && mem_gnt);
        check_val("mem_req", bus.mem_req_o, req != 4'b0);
        if (req != 4'b0) begin
            check_val("mem_add", bus.mem_add_o, pl[w].add);
            check_val("mem_wen", bus.mem_wen_o, pl[w].wen);
            check_val("mem_data", bus.mem_data_o, pl[w].data);
            check_val("mem_be", bus.mem_be_o, pl[w].be);
        end
        check_val("r_valid", obs_rv, (m_resp_ch >= 0) ? (64'd1 << m_resp_ch) : 64'd0);
        check_val("r_id", obs_rid, m_resp_id);
        check_val("r_data", bus.ch_r_data_o, rdata);
        if (clear) begin
            model_reset();
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!req[i] || (g && w == i)) m_stall[i] = 0;
                else if (m_stall[i] < MAX_STALL) m_stall[i]++;
            end
            if (g) begin
                m_ptr = (w + 1) % N_CH;
                if (keep) m_budget++;
                else begin m_owner = w; m_budget = 1; end
                m_resp_ch = w;
                m_resp_id = int'(pl[w].id);
            end else begin
                m_resp_ch = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; req = 4'b0;
        step();
        clear = 1'b0;
    endtask

    int wseq [9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
    int exp_ch;

    initial begin
        rst = 1'b1; clear = 1'b0; policy = 2'd0; weight = 16'h1111;
        req = 4'b0; mem_gnt = 1'b0; rdata = 32'h0;
        for (int i = 0; i < N_CH; i++) begin
            pl[i].add  = 13'(16'h100 + i);
            pl[i].wen  = 1'b1;
            pl[i].data = 32'hA000_0000 + i;
            pl[i].be   = 4'hF;
            pl[i].id   = 8'h10 + 8'(i);
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        // Reset state; grant and mem_req still follow inputs combinationally.
        req = 4'b0100; mem_gnt = 1'b1; drive();
        #1;
        check_val("rst_r_valid", bus.ch_r_valid_o, 4'b0);
        check_val("rst_r_id", bus.ch_r_id_o, 8'h0);
        check_val("rst_starve", starve, 1'b0);
        check_val("rst_gnt", bus.ch_gnt_o, 4'b0100);
        check_val("rst_mem_req", bus.mem_req_o, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0; req = 4'b0;
        model_reset();

        // RR fairness
        policy = 2'd0; req = 4'hF; mem_gnt = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check_val("rr_seq", obs_gnt, 64'd1 << (k % 4));
            if (k > 0) begin
                check_val("rr_rvalid", obs_rv, 64'd1 << ((k - 1) % 4));
                check_val("rr_rid", obs_rid, 8'h10 + 8'((k - 1) % 4));
            end
        end
        req = 4'b0; step();
        check_val("rr_last_rvalid", obs_rv, 4'b1000);

        // Weighted budget {3,1,1,1}
        do_clear();
        policy = 2'd2; weight = 16'h1113; req = 4'hF;
        for (int k = 0; k < 9; k++) begin
            step();
            check_val("wt_seq", obs_gnt, 64'd1 << wseq[k]);
        end

        // Bank back-pressure
        do_clear();
        policy = 2'd0; req = 4'b0010; mem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("bp_gnt", obs_gnt, 4'b0);
            check_val("bp_rvalid", obs_rv, 4'b0);
        end
        mem_gnt = 1'b1; step();
        check_val("bp_first", obs_gnt, 4'b0010);
        req = 4'hF; mem_gnt = 1'b0; step(); step();
        mem_gnt = 1'b1; step();
        check_val("bp_ptr_kept", obs_gnt, 4'b0100);

        // Starvation override (or its absence)
        do_clear();
        policy = 2'd3; req = 4'b1001; mem_gnt = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
`ifdef TCDM_ARB_STARVATION_EN
            exp_ch = (k == 15) ? 0 : 3;
            check_val("stv_starve", obs_starve, k == 15);
`else
            exp_ch = 3;
            check_val("stv_starve", obs_starve, 1'b0);
`endif
            check_val("stv_gnt", obs_gnt, 64'd1 << exp_ch);
        end

        // Clear coinciding with a read grant on ch 2
        do_clear();
        policy = 2'd0; req = 4'hF; step();
        req = 4'b0100; clear = 1'b1; step();
        check_val("clr_gnt", obs_gnt, 4'b0100);
        clear = 1'b0; req = 4'b0; step();
        check_val("clr_rvalid", obs_rv, 4'b0);
        req = 4'hF; step();
        check_val("clr_ptr", obs_gnt, 4'b0001);

        // Asynchronous reset with a response pending
        check_val("pre_rst_rvalid", bus.ch_r_valid_o, 4'b0001);
        rst = 1'b1;
        #1;
        check_val("arst_rvalid", bus.ch_r_valid_o, 4'b0);
        check_val("arst_rid", bus.ch_r_id_o, 8'h0);
        check_val("arst_starve", starve, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 7) == 0) policy = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) weight = 16'($urandom);
            req     = 4'($urandom);
            mem_gnt = ($urandom_range(0, 6) != 0);
            clear   = ($urandom_range(0, 49) == 0);
            rdata   = $urandom;
            for (int i = 0; i < N_CH; i++) begin
                pl[i].add  = 13'($urandom);
                pl[i].wen  = 1'($urandom);
                pl[i].data = $urandom;
                pl[i].be   = 4'($urandom);
                pl[i].id   = 8'($urandom);
            end
            step();
        end
        clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
